// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: opcode map, control FSM states and
// the status flag payload.
package alu_pkg;

    localparam int unsigned ALU_SEL_W = 3;

    // Opcode map; values 000..100 match the legacy combinational ALU.
    typedef enum logic [ALU_SEL_W-1:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_NOT  = 3'b100,
        OP_XOR  = 3'b101,
        OP_MUL  = 3'b110,
        OP_RSVD = 3'b111
    } alu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } alu_state_e;

    typedef struct packed {
        logic carry;
        logic zero;
        logic overflow;
    } alu_flags_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one multiplier bit per clock, WIDTH steps
// after start. done pulses for one cycle together with the final product.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned PROD_W = 2 * WIDTH;
    localparam int unsigned CNT_W  = $clog2(WIDTH);

    logic [PROD_W-1:0] mcand;
    logic [PROD_W-1:0] acc;
    logic [WIDTH-1:0]  mplier;
    logic [CNT_W-1:0]  count;
    logic              busy;

    // Load operands on start, then accumulate shifted multiplicand per bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            count  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else if (start) begin
            mcand  <= PROD_W'(a);
            acc    <= '0;
            mplier <= b;
            count  <= '0;
            busy   <= 1'b1;
            done   <= 1'b0;
        end else if (busy) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + CNT_W'(1);
            if (count == CNT_W'(WIDTH - 1)) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end else begin
            done <= 1'b0;
        end
    end

    assign product = acc;

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes on both sides.
// Optional feature macro: ALU_MUL_EN enables the sequential multiply (opcode
// 110); without it opcode 110 behaves as reserved and completes in one cycle.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SEL_W = ALU_SEL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SEL_W-1:0] sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             overflow
);

    alu_op_e          op;
    logic             accept;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic             alu_ovf;
    logic             load;
    logic [WIDTH-1:0] load_res;
    alu_flags_t       load_flags;
    alu_flags_t       flags;
    logic             valid_next;
    logic             slot_free;

    assign op        = alu_op_e'(sel);
    assign slot_free = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign add_sum   = {1'b0, a} + {1'b0, b};
    assign sub_diff  = {1'b0, a} - {1'b0, b};

    // Single-cycle datapath; opcode 110 falls to the reserved result here.
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res   = add_sum[WIDTH-1:0];
                alu_carry = add_sum[WIDTH];
                alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res   = sub_diff[WIDTH-1:0];
                alu_carry = sub_diff[WIDTH];
                alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_NOT:  alu_res = ~a;
            OP_XOR:  alu_res = a ^ b;
            default: alu_res = '0;
        endcase
    end

`ifdef ALU_MUL_EN
    localparam int unsigned PROD_W = 2 * WIDTH;

    alu_state_e        state;
    alu_state_e        state_next;
    logic              mul_start;
    logic              mul_done;
    logic [PROD_W-1:0] mul_prod;

    alu_mul_seq #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_prod)
    );

    assign in_ready = !rst && (state == ST_IDLE) && slot_free;

    // Control FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, multiplier start and output-register load selection.
    always_comb begin
        state_next          = state;
        mul_start           = 1'b0;
        load                = 1'b0;
        load_res            = alu_res;
        load_flags.carry    = alu_carry;
        load_flags.overflow = alu_ovf;
        load_flags.zero     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (op == OP_MUL) begin
                        mul_start  = 1'b1;
                        state_next = ST_MUL;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                if (mul_done) begin
                    load                = 1'b1;
                    load_res            = mul_prod[WIDTH-1:0];
                    load_flags.carry    = |mul_prod[PROD_W-1:WIDTH];
                    load_flags.overflow = 1'b0;
                    state_next          = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        load_flags.zero = (load_res == '0);
        valid_next = load ? 1'b1 : (out_valid && !out_ready);
    end
`else
    assign in_ready = !rst && slot_free;

    // Every accepted operation completes in one cycle.
    always_comb begin
        load                = accept;
        load_res            = alu_res;
        load_flags.carry    = alu_carry;
        load_flags.overflow = alu_ovf;
        load_flags.zero     = (alu_res == '0);
        valid_next          = load ? 1'b1 : (out_valid && !out_ready);
    end
`endif

    // Output slot: result and flags hold until a new result is loaded.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
        end else begin
            out_valid <= valid_next;
            if (load) begin
                result <= load_res;
                flags  <= load_flags;
            end
        end
    end

    assign carry    = flags.carry;
    assign zero     = flags.zero;
    assign overflow = flags.overflow;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe (WIDTH=8). Covers the MUL path
// when ALU_MUL_EN is defined, and the reserved behaviour of opcode 110 otherwise.
module tb_alu_pipe;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;
    logic             overflow;

    int n_tests = 0;
    int n_fail  = 0;

    alu_pipe #(
        .WIDTH (WIDTH),
        .SEL_W (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .zero      (zero),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [7:0] r, input logic c,
                             input logic z, input logic v);
        check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        check({tag, ".result"},    32'(result),    32'(r));
        check({tag, ".carry"},     32'(carry),     32'(c));
        check({tag, ".zero"},      32'(zero),      32'(z));
        check({tag, ".overflow"},  32'(overflow),  32'(v));
    endtask

    task automatic check_cleared(input string tag);
        check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".result"},    32'(result),    32'd0);
        check({tag, ".carry"},     32'(carry),     32'd0);
        check({tag, ".zero"},      32'(zero),      32'd0);
        check({tag, ".overflow"},  32'(overflow),  32'd0);
    endtask

    // Present one operation, confirm it is accepted, return just after the edge.
    task automatic send(input logic [2:0] s, input logic [7:0] x, input logic [7:0] y);
        sel      = s;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        @(negedge clk);
        check("accept_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Walk through a multiply: in_ready low for WIDTH+1 cycles, result at edge N+WIDTH+1.
    task automatic mul_wait(input string tag);
        for (int i = 0; i < int'(WIDTH) + 1; i++) begin
            @(negedge clk);
            check({tag, ".busy_ready"}, 32'(in_ready),  32'd0);
            check({tag, ".busy_valid"}, 32'(out_valid), 32'd0);
            @(posedge clk);
        end
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        sel       = 3'b000;
        out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.in_ready", 32'(in_ready), 32'd0);
        check_cleared("rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst.in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // ADD with carry out
        send(3'b000, 8'hF0, 8'h20);
        check_out("add_f0_20", 8'h10, 1'b0 | 1'b1, 1'b0, 1'b0);

        // SUB with signed overflow, then SUB to zero
        send(3'b001, 8'h80, 8'h01);
        check_out("sub_80_01", 8'h7F, 1'b0, 1'b0, 1'b1);
        send(3'b001, 8'h05, 8'h05);
        check_out("sub_05_05", 8'h00, 1'b0, 1'b1, 1'b0);

        // Back-to-back logic ops
        send(3'b010, 8'h0F, 8'h3C);
        check_out("and", 8'h0C, 1'b0, 1'b0, 1'b0);
        send(3'b011, 8'h0F, 8'h3C);
        check_out("or", 8'h3F, 1'b0, 1'b0, 1'b0);
        send(3'b101, 8'h0F, 8'h3C);
        check_out("xor", 8'h33, 1'b0, 1'b0, 1'b0);
        send(3'b100, 8'h0F, 8'h3C);
        check_out("not", 8'hF0, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("drain.out_valid", 32'(out_valid), 32'd0);

        // Backpressure, then simultaneous output and input transfer
        out_ready = 1'b0;
        send(3'b000, 8'h01, 8'h01);
        check_out("bp_add", 8'h02, 1'b0, 1'b0, 1'b0);
        sel      = 3'b001;
        a        = 8'h09;
        b        = 8'h01;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp.in_ready", 32'(in_ready),  32'd0);
            check("bp.result",   32'(result),    32'h02);
            check("bp.valid",    32'(out_valid), 32'd1);
            @(posedge clk);
        end
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release.in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        check_out("bp_swap_sub", 8'h08, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;

`ifdef ALU_MUL_EN
        // Sequential multiply
        send(3'b110, 8'h12, 8'h10);
        in_valid = 1'b0;
        mul_wait("mul_12_10");
        check_out("mul_12_10", 8'h20, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        send(3'b110, 8'h03, 8'h04);
        in_valid = 1'b0;
        mul_wait("mul_03_04");
        check_out("mul_03_04", 8'h0C, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;

        // Reset in the 4th cycle of a multiply
        send(3'b110, 8'h12, 8'h10);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
`else
        // Opcode 110 is reserved without the multiplier
        send(3'b110, 8'h12, 8'h10);
        in_valid = 1'b0;
        check_out("mul_rsvd", 8'h00, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1;

        // Reset while a result is held under backpressure
        out_ready = 1'b0;
        send(3'b101, 8'h55, 8'h0F);
        in_valid = 1'b0;
        check_out("xor_hold", 8'h5A, 1'b0, 1'b0, 1'b0);
`endif
        rst = 1'b1;
        @(negedge clk);
        check("midrst.in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check_cleared("midrst");
        check("midrst.in_ready_after", 32'(in_ready), 32'd1);
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("midrst.no_result", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        // Reserved opcode
        send(3'b111, 8'hFF, 8'hFF);
        in_valid = 1'b0;
        check_out("rsvd", 8'h00, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
